// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Direction codes and arbiter state type shared by the input
//               front-end and the player-movement block.
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    localparam logic [2:0] DIR_LEFT  = 3'd0;
    localparam logic [2:0] DIR_RIGHT = 3'd1;
    localparam logic [2:0] DIR_UP    = 3'd2;
    localparam logic [2:0] DIR_DOWN  = 3'd3;
    localparam logic [2:0] DIR_NONE  = 3'd4;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ACT_L = 3'd1,
        ACT_R = 3'd2,
        ACT_U = 3'd3,
        ACT_D = 3'd4
    } arb_state_t;

    function automatic logic [2:0] state_to_dir(input arb_state_t s);
        case (s)
            ACT_L:   return DIR_LEFT;
            ACT_R:   return DIR_RIGHT;
            ACT_U:   return DIR_UP;
            ACT_D:   return DIR_DOWN;
            default: return DIR_NONE;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : 2-FF synchroniser plus stable-count debouncer for one raw
//               button, with one-cycle press/release events.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_level,
    output logic o_press,
    output logic o_release
);

    localparam int                  c_cnt_w    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cnt_w-1:0]  c_cnt_last = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    logic               r_sync0;
    logic               r_sync1;
    logic [c_cnt_w-1:0] r_cnt;

    // Events are registered alongside the level flip so they line up with it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_sync0   <= 1'b0;
            r_sync1   <= 1'b0;
            r_cnt     <= '0;
            o_level   <= 1'b0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
        end else begin
            r_sync0   <= i_btn;
            r_sync1   <= r_sync0;
            o_press   <= 1'b0;
            o_release <= 1'b0;
            if (r_sync1 == o_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_cnt     <= '0;
                o_level   <= r_sync1;
                o_press   <= r_sync1;
                o_release <= ~r_sync1;
            end else begin
                r_cnt <= r_cnt + c_cnt_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/game_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : game_input_ctrl
// Description : Debounces four direction buttons, resolves them with
//               last-pressed-wins arbitration and generates move_clock.
// Revision    : 1.0 - initial release
// ============================================================================
module game_input_ctrl
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int MOVE_DIV        = 250000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       pause,
    output logic       left,
    output logic       right,
    output logic       up,
    output logic       down,
    output logic       move_clock,
    output logic [2:0] dir_code
);

    localparam int                  c_div_w    = (MOVE_DIV > 1) ? $clog2(MOVE_DIV) : 1;
    localparam logic [c_div_w-1:0]  c_div_last = c_div_w'(MOVE_DIV - 1);

    logic [3:0]         w_raw;
    logic [3:0]         w_level;
    logic [3:0]         w_press;
    logic [3:0]         w_release;
    logic               w_active_rel;
    arb_state_t         r_state;
    arb_state_t         w_next;
    logic [c_div_w-1:0] r_div_cnt;

    // Bit order doubles as arbitration priority: index 0 (left) is highest.
    assign w_raw = {btn_down, btn_up, btn_right, btn_left};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_debounce (
            .clk       (clk),
            .reset     (reset),
            .i_btn     (w_raw[i]),
            .o_level   (w_level[i]),
            .o_press   (w_press[i]),
            .o_release (w_release[i])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        w_active_rel = 1'b0;
        case (r_state)
            ACT_L:   w_active_rel = w_release[0];
            ACT_R:   w_active_rel = w_release[1];
            ACT_U:   w_active_rel = w_release[2];
            ACT_D:   w_active_rel = w_release[3];
            default: w_active_rel = 1'b0;
        endcase

        if (|w_press) begin
            if      (w_press[0]) w_next = ACT_L;
            else if (w_press[1]) w_next = ACT_R;
            else if (w_press[2]) w_next = ACT_U;
            else                 w_next = ACT_D;
        end else if (w_active_rel) begin
            if      (w_level[0]) w_next = ACT_L;
            else if (w_level[1]) w_next = ACT_R;
            else if (w_level[2]) w_next = ACT_U;
            else if (w_level[3]) w_next = ACT_D;
            else                 w_next = IDLE;
        end
    end

    // Outputs decode the next state so arbitration and output share one cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            left     <= 1'b0;
            right    <= 1'b0;
            up       <= 1'b0;
            down     <= 1'b0;
            dir_code <= DIR_NONE;
        end else begin
            left     <= !pause && (w_next == ACT_L);
            right    <= !pause && (w_next == ACT_R);
            up       <= !pause && (w_next == ACT_U);
            down     <= !pause && (w_next == ACT_D);
            dir_code <= pause ? DIR_NONE : state_to_dir(w_next);
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_div_cnt  <= '0;
            move_clock <= 1'b0;
        end else if (!pause) begin
            if (r_div_cnt == c_div_last) begin
                r_div_cnt  <= '0;
                move_clock <= ~move_clock;
            end else begin
                r_div_cnt <= r_div_cnt + c_div_w'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_game_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_input_ctrl
// Description : Directed and randomized bench for game_input_ctrl against a
//               cycle-level behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_input_ctrl;
    import game_pkg::*;

    localparam int D  = 4;
    localparam int MD = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn;
    logic       pause;
    logic       left, right, up, down, move_clock;
    logic [2:0] dir_code;
    logic [3:0] got_oh;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    bit [3:0]   m_s0, m_s1, m_lvl, m_prs;
    int         m_run [4];
    int         m_act;
    int         m_div;
    logic [2:0] e_dir;
    logic       e_mc;

    always #5 clk = ~clk;

    assign got_oh = {down, up, right, left};

    game_input_ctrl #(
        .DEBOUNCE_CYCLES (D),
        .MOVE_DIV        (MD)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_left   (btn[0]),
        .btn_right  (btn[1]),
        .btn_up     (btn[2]),
        .btn_down   (btn[3]),
        .pause      (pause),
        .left       (left),
        .right      (right),
        .up         (up),
        .down       (down),
        .move_clock (move_clock),
        .dir_code   (dir_code)
    );

    function automatic logic [3:0] exp_oh(input logic [2:0] d);
        case (d)
            3'd0:    return 4'b0001;
            3'd1:    return 4'b0010;
            3'd2:    return 4'b0100;
            3'd3:    return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    // Advance the model by one clock using the inputs about to be sampled.
    task automatic model_step();
        int nxt;
        if (!reset) begin
            m_s0 = '0; m_s1 = '0; m_lvl = '0; m_prs = '0;
            for (int i = 0; i < 4; i++) m_run[i] = 0;
            m_act = 4; m_div = 0; e_dir = 3'd4; e_mc = 1'b0;
        end else begin
            nxt = m_act;
            if (m_prs != 0) begin
                for (int i = 3; i >= 0; i--) if (m_prs[i]) nxt = i;
            end else if (m_act != 4 && !m_lvl[m_act]) begin
                nxt = 4;
                for (int i = 3; i >= 0; i--) if (m_lvl[i]) nxt = i;
            end
            m_act = nxt;
            e_dir = pause ? 3'd4 : 3'(m_act);
            for (int i = 0; i < 4; i++) begin
                m_prs[i] = 1'b0;
                if (m_s1[i] == m_lvl[i]) begin
                    m_run[i] = 0;
                end else begin
                    m_run[i]++;
                    if (m_run[i] == D) begin
                        m_lvl[i] = ~m_lvl[i];
                        m_run[i] = 0;
                        m_prs[i] = m_lvl[i];
                    end
                end
            end
            m_s1 = m_s0;
            m_s0 = btn;
            if (!pause) begin
                m_div++;
                if (m_div == MD) begin
                    m_div = 0;
                    e_mc  = ~e_mc;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_dir(input logic [2:0] code, output int n);
        n = -1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (dir_code === code) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        int n;
        reset = 1'b0; btn = 4'hF; pause = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        n_checks++;
        if ({got_oh, dir_code, move_clock} !== {4'b0000, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_state: got oh=%b dir=%0d mc=%b, want oh=0000 dir=4 mc=0",
                     got_oh, dir_code, move_clock);
        end
        reset = 1'b1;
        wait_dir(DIR_LEFT, n);
        n_checks++;
        if (n != 7 || got_oh !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_held_press: got latency=%0d oh=%b, want latency=7 oh=0001", n, got_oh);
        end
        btn = 4'h0;
        wait_dir(DIR_NONE, n);
        n_checks++;
        if (n != 7) begin
            n_fail++;
            $display("FAIL release_latency: got %0d, want 7", n);
        end
    endtask

    task automatic test_debounce();
        int n;
        btn[2] = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        btn[2] = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if (up !== 1'b0 || dir_code !== 3'd4) begin
                n_fail++;
                $display("FAIL glitch_reject: got up=%b dir=%0d, want up=0 dir=4", up, dir_code);
            end
        end
        btn[2] = 1'b1;
        wait_dir(DIR_UP, n);
        n_checks++;
        if (n != 7 || up !== 1'b1) begin
            n_fail++;
            $display("FAIL debounce_press: got latency=%0d up=%b, want latency=7 up=1", n, up);
        end
        btn = 4'h0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_last_pressed();
        int n;
        btn[0] = 1'b1;
        wait_dir(DIR_LEFT, n);
        n_checks++;
        if (left !== 1'b1) begin
            n_fail++;
            $display("FAIL lpw_left: got left=%b, want 1", left);
        end
        btn[1] = 1'b1;
        wait_dir(DIR_RIGHT, n);
        n_checks++;
        if (got_oh !== 4'b0010) begin
            n_fail++;
            $display("FAIL lpw_right_takeover: got oh=%b dir=%0d, want oh=0010 dir=1", got_oh, dir_code);
        end
        btn[1] = 1'b0;
        wait_dir(DIR_LEFT, n);
        n_checks++;
        if (n != 7 || got_oh !== 4'b0001) begin
            n_fail++;
            $display("FAIL lpw_fallback_left: got latency=%0d oh=%b, want latency=7 oh=0001", n, got_oh);
        end
        btn = 4'h0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_simultaneous();
        int n;
        btn[2] = 1'b1; btn[3] = 1'b1;
        wait_dir(DIR_UP, n);
        n_checks++;
        if (n != 7 || got_oh !== 4'b0100) begin
            n_fail++;
            $display("FAIL simul_priority: got latency=%0d oh=%b, want latency=7 oh=0100", n, got_oh);
        end
        btn[2] = 1'b0;
        wait_dir(DIR_DOWN, n);
        n_checks++;
        if (n != 7 || got_oh !== 4'b1000) begin
            n_fail++;
            $display("FAIL simul_fallback_down: got latency=%0d oh=%b, want latency=7 oh=1000", n, got_oh);
        end
        btn = 4'h0;
        for (int k = 0; k < 8; k++) tick();
    endtask

    task automatic test_divider();
        logic prev;
        int   last_t, ntog;
        prev = move_clock; last_t = -1; ntog = 0;
        for (int t = 0; t < 30; t++) begin
            tick();
            if (move_clock !== prev) begin
                if (last_t >= 0) begin
                    n_checks++;
                    if (t - last_t != MD) begin
                        n_fail++;
                        $display("FAIL divider_half_period: got %0d, want %0d", t - last_t, MD);
                    end
                end
                last_t = t;
                ntog++;
                prev = move_clock;
            end
        end
        n_checks++;
        if (ntog != 10) begin
            n_fail++;
            $display("FAIL divider_toggle_count: got %0d, want 10", ntog);
        end
    endtask

    task automatic test_pause();
        int   n;
        logic mc_hold;
        btn[0] = 1'b1;
        wait_dir(DIR_LEFT, n);
        mc_hold = move_clock;
        pause = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            n_checks++;
            if ({got_oh, dir_code, move_clock} !== {4'b0000, 3'd4, mc_hold}) begin
                n_fail++;
                $display("FAIL pause_hold: got oh=%b dir=%0d mc=%b, want oh=0000 dir=4 mc=%b",
                         got_oh, dir_code, move_clock, mc_hold);
            end
        end
        pause = 1'b0;
        for (int k = 0; k < 12; k++) begin
            tick();
            n_checks++;
            if ({got_oh, dir_code, move_clock} !== {exp_oh(e_dir), e_dir, e_mc}) begin
                n_fail++;
                $display("FAIL pause_resume: got oh=%b dir=%0d mc=%b, want oh=%b dir=%0d mc=%b",
                         got_oh, dir_code, move_clock, exp_oh(e_dir), e_dir, e_mc);
            end
        end
        for (int k = 0; k < 10 && move_clock !== 1'b1; k++) tick();
        tick();
        reset = 1'b0;
        tick();
        n_checks++;
        if ({got_oh, dir_code, move_clock} !== {4'b0000, 3'd4, 1'b0}) begin
            n_fail++;
            $display("FAIL midop_reset: got oh=%b dir=%0d mc=%b, want oh=0000 dir=4 mc=0",
                     got_oh, dir_code, move_clock);
        end
        reset = 1'b1;
        btn = 4'h0;
        for (int k = 0; k < 10; k++) tick();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, 9) == 0) btn[i] = ~btn[i];
            if ($urandom_range(0, 39) == 0) pause = ~pause;
            reset = ($urandom_range(0, 399) != 0);
            tick();
            n_checks++;
            if ({got_oh, dir_code, move_clock} !== {exp_oh(e_dir), e_dir, e_mc}) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got oh=%b dir=%0d mc=%b, want oh=%b dir=%0d mc=%b",
                         c, got_oh, dir_code, move_clock, exp_oh(e_dir), e_dir, e_mc);
            end
        end
        reset = 1'b1;
        pause = 1'b0;
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_last_pressed();
        test_simultaneous();
        test_divider();
        test_pause();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
